// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetches words from imem into a DEPTH-entry {pc,instr} queue for ID; a redirect flushes the queue and in-flight responses.
// Optional feature macro IF_BYPASS_EN forwards a response to ID in its arrival cycle when the queue is empty.
module if_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] RESET_AL = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, rsp_pc_q, redirect_al;
  entry_t        queue_q [DEPTH];
  entry_t        head, wr_entry;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, outstanding_q, drop_q, drop_nxt;
  logic [CW:0]   inflight;
  logic          grant, rsp_ok, accept, bypass, push, pop, q_nempty;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign redirect_al = {redirect_pc_i[31:2], 2'b00};
  assign inflight    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign q_nempty    = (count_q != '0);
  assign head        = queue_q[rd_ptr_q];
  assign wr_entry    = '{pc: rsp_pc_q, instr: imem_rdata_i};

  // Responses with nothing outstanding belong to requests issued before a reset.
  assign rsp_ok   = imem_rvalid_i && (outstanding_q != '0);
  assign grant    = imem_req_o && imem_gnt_i;
  assign accept   = rsp_ok && !redirect_i && (state_q == RUN);
  assign drop_nxt = outstanding_q - {{(CW-1){1'b0}}, rsp_ok};

`ifdef IF_BYPASS_EN
  assign bypass = accept && !q_nempty;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid_o = (q_nempty && !redirect_i) || bypass;
  assign pop           = q_nempty && !redirect_i && id_ready_i;
  assign push          = accept && !(bypass && id_ready_i);
  assign imem_addr_o   = fetch_pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_i)
      state_d = (drop_nxt != '0) ? FLUSH : RUN;
    else if (state_q == FLUSH && rsp_ok && drop_q <= CW'(1))
      state_d = RUN;
  end

  // Queue plus in-flight responses never exceed DEPTH, so a push can always land.
  always_comb begin
    imem_req_o = 1'b0;
    if (!rst_i && state_q == RUN && !redirect_i && inflight < (CW+1)'(DEPTH))
      imem_req_o = 1'b1;
  end

  always_comb begin
    instr_o = '0;
    pc_o    = '0;
    if (q_nempty && !redirect_i) begin
      instr_o = head.instr;
      pc_o    = head.pc;
    end else if (bypass) begin
      instr_o = imem_rdata_i;
      pc_o    = rsp_pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_AL;
      rsp_pc_q      <= RESET_AL;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      case ({grant, rsp_ok})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
      if (redirect_i) begin
        fetch_pc_q <= redirect_al;
        rsp_pc_q   <= redirect_al;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        drop_q     <= drop_nxt;
      end else begin
        if (grant)  fetch_pc_q <= fetch_pc_q + 32'd4;
        if (accept) rsp_pc_q   <= rsp_pc_q + 32'd4;
        if (state_q == FLUSH && rsp_ok && drop_q != '0) drop_q <= drop_q - 1'b1;
        if (push)   wr_ptr_q   <= wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_q   <= rd_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) queue_q[wr_ptr_q] <= wr_entry;
  end
endmodule
